// File: rtl/aes_bist_ctrl_if.sv
// BIST control/status bundle between the sequencer and the AES LFSR/MISR wrapper.
// Latency: none, this is wiring only.
// Backpressure: none; aes_done_valid is a strobe that cannot be stalled.
interface aes_bist_ctrl_if;
  logic       start;
  logic       aes_done_valid;
  logic       aes_done;
  logic [7:0] sig_in;
  logic       is_bist;
  logic       enable_lsfr_misr;
  logic       bist_clear;
  logic       bist_busy;
  logic       bist_done;
  logic       bist_pass;
  logic       bist_timeout;
  logic [7:0] sig_captured;

  // Sequencer side: drives the wrapper controls and the status.
  modport master (
    input  start, aes_done_valid, aes_done, sig_in,
    output is_bist, enable_lsfr_misr, bist_clear, bist_busy,
           bist_done, bist_pass, bist_timeout, sig_captured
  );

  // Wrapper / test-access side.
  modport slave (
    output start, aes_done_valid, aes_done, sig_in,
    input  is_bist, enable_lsfr_misr, bist_clear, bist_busy,
           bist_done, bist_pass, bist_timeout, sig_captured
  );
endinterface

// File: rtl/aes_bist_ctrl.sv
// BIST sequencer: clears the wrapper, counts output bytes, then checks the MISR signature.
// Latency: CLEAR 1 cycle after the start edge, RUN after 2; done 3 cycles after the last beat.
// Backpressure: none; beats are counted as they arrive and a stalled core ends in a timeout.
module aes_bist_ctrl #(
  parameter logic [7:0] GOLDEN_SIG    = 8'hC0,
  parameter int         NUM_OUT_BYTES = 16,
  parameter int         TIMEOUT_CYC   = 1023
) (
  input  logic          clk,
  input  logic          rst,
  aes_bist_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(NUM_OUT_BYTES + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_OUT_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_PASS    = 3'd5;
  localparam logic [2:0] S_FAIL    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          start_q;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic [7:0]    sig_q, sig_d;
  logic          start_edge;

  // aes_done is informational; the run is delimited by the beat count alone.
  logic unused_aes_done;
  assign unused_aes_done = bus.aes_done;

  assign start_edge = bus.start & ~start_q;

  // Next-state and counter updates; counters saturate rather than wrap.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    sig_d      = sig_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        byte_cnt_d = '0;
        tmo_cnt_d  = '0;
        tmo_flag_d = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.aes_done_valid && (byte_cnt_q != '1)) byte_cnt_d = byte_cnt_q + 1'b1;
        // The final beat takes priority over a coincident timeout.
        if (bus.aes_done_valid && (byte_cnt_q == LAST_BYTE)) begin
          state_d = S_SETTLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = S_FAIL;
          tmo_flag_d = 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        sig_d   = bus.sig_in;
        state_d = (bus.sig_in == GOLDEN_SIG) ? S_PASS : S_FAIL;
      end
      S_PASS, S_FAIL: begin
        if (start_edge) begin
          state_d    = S_CLEAR;
          tmo_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, start-edge history and captured signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
      sig_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.start;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
      sig_q      <= sig_d;
    end
  end

  // Outputs decode from the registered state, so an async reset clears them at once.
  assign bus.is_bist          = (state_q != S_IDLE);
  assign bus.enable_lsfr_misr = (state_q == S_RUN);
  assign bus.bist_clear       = (state_q == S_CLEAR);
  assign bus.bist_busy        = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                                (state_q == S_SETTLE) || (state_q == S_COMPARE);
  assign bus.bist_done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign bus.bist_pass        = (state_q == S_PASS);
  assign bus.bist_timeout     = (state_q == S_FAIL) && tmo_flag_q;
  assign bus.sig_captured     = sig_q;

endmodule
